serial_bit_feeder: RTL and testbench

Upstream stage for the Moore "101" sequence detector. Accepts W-bit words over a valid/ready handshake and emits them as a serial bit stream, one bit per accepted cycle. `bit_out` drives the detector's `in` input, and `bit_valid && bit_ready` gates the detector's state-register update. A one-word holding buffer allows back-to-back words with no gap between them.

---
 rtl/serial_bit_feeder.sv | 126 ++++++++++++
 tb/tb_serial_bit_feeder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// Word-to-bit serializer feeding the Moore "101" detector: a one-word holding
// buffer in front of a shift register lets words stream with no bit gaps.
module serial_bit_feeder #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [W-1:0] din,
  output logic         bit_out,
  output logic         bit_valid,
  input  logic         bit_ready,
  output logic         bit_last,
  output logic [15:0]  words_sent
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   words_q, words_d;

  logic accept_s;
  logic consume_s;
  logic last_s;
  logic out_bit_s;
  logic [W-1:0] shifted_s;

  // Handshake decodes and the serial output, all derived from registers
  always_comb begin
    din_ready  = !hold_full_q && !reset;
    bit_valid  = (state_q == SHIFT);
    last_s     = (cnt_q == LAST_IDX);
    out_bit_s  = MSB_FIRST ? sreg_q[W-1] : sreg_q[0];
    bit_out    = bit_valid && out_bit_s;
    bit_last   = bit_valid && last_s;
    accept_s   = din_valid && din_ready;
    consume_s  = bit_valid && bit_ready;
    shifted_s  = MSB_FIRST ? {sreg_q[W-2:0], 1'b0} : {1'b0, sreg_q[W-1:1]};
    words_sent = words_q;
  end

  // Next-state logic: buffer fill, hold-to-shift transfer and bit shifting
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    words_d     = words_q;

    // Accept needs an empty buffer and transfer needs a full one, so the two
    // writes to hold_full_d below never collide.
    if (accept_s) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d     = SHIFT;
          sreg_d      = hold_q;
          cnt_d       = '0;
          hold_full_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (consume_s && last_s) begin
          words_d = words_q + 16'd1;
          if (hold_full_q) begin
            state_d     = SHIFT;
            sreg_d      = hold_q;
            cnt_d       = '0;
            hold_full_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (consume_s) begin
          sreg_d = shifted_s;
          cnt_d  = cnt_q + CW'(1);
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sreg_q      <= '0;
      cnt_q       <= '0;
      words_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      words_q     <= words_d;
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench: two feeders (MSB-first and LSB-first) share one stimulus
// stream; accepted words are queued and each monitor walks them bit by bit.
module tb_serial_bit_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic         bit_ready = 1'b1;

  logic        dr [2];
  logic        bo [2];
  logic        bv [2];
  logic        bl [2];
  logic [15:0] ws [2];

  int br_mode = 0;
  int errors = 0;
  int checks = 0;

  logic [W-1:0] wq [$];
  int   wi [2];
  int   bi [2];
  int   exp_words [2];
  logic pst [2];
  logic pbo [2];
  logic pbl [2];

  serial_bit_feeder #(.W(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din_ready(dr[0]), .din(din),
    .bit_out(bo[0]), .bit_valid(bv[0]), .bit_ready(bit_ready), .bit_last(bl[0]),
    .words_sent(ws[0])
  );

  serial_bit_feeder #(.W(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din_ready(dr[1]), .din(din),
    .bit_out(bo[1]), .bit_valid(bv[1]), .bit_ready(bit_ready), .bit_last(bl[1]),
    .words_sent(ws[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Downstream readiness pattern: 0 always ready, 1 random, 2 stalled
  always @(posedge clk) begin
    #1;
    case (br_mode)
      0:       bit_ready = 1'b1;
      1:       bit_ready = ($urandom_range(0, 3) != 0);
      default: bit_ready = 1'b0;
    endcase
  end

  // Every handshake seen before an edge becomes a queued expected word
  always @(negedge clk) begin
    if (!reset && din_valid && dr[0]) wq.push_back(din);
  end

  // Monitor: walk queued words bit by bit for each bit order
  always @(negedge clk) begin
    logic [W-1:0] w;
    logic eb;
    if (!reset) chk("din_ready_match", dr[1], dr[0]);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        chk($sformatf("din_ready_in_reset%0d", d), dr[d], 1'b0);
        wi[d] = wq.size();
        bi[d] = 0;
        exp_words[d] = 0;
        pst[d] = 1'b0;
      end else begin
        chk($sformatf("words_sent%0d", d), ws[d], exp_words[d] & 32'hFFFF);
        if (!bv[d]) begin
          chk($sformatf("idle_outputs%0d", d), {bo[d], bl[d]}, 2'b00);
        end else begin
          if (pst[d]) chk($sformatf("stall_hold%0d", d), {bo[d], bl[d]}, {pbo[d], pbl[d]});
          if (bit_ready) begin
            if (wi[d] >= wq.size()) begin
              fail_now($sformatf("unexpected_bit%0d", d));
            end else begin
              w  = wq[wi[d]];
              eb = (d == 0) ? w[W-1-bi[d]] : w[bi[d]];
              chk($sformatf("bit%0d_w%0d_b%0d", d, wi[d], bi[d]), {bo[d], bl[d]},
                  {eb, (bi[d] == W - 1)});
              bi[d]++;
              if (bi[d] == W) begin
                bi[d] = 0;
                wi[d]++;
                exp_words[d]++;
              end
            end
          end
        end
        pst[d] = bv[d] && !bit_ready;
        pbo[d] = bo[d];
        pbl[d] = bl[d];
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic wait_accept(input int bound);
    int t = 0;
    while (t < bound) begin
      @(negedge clk);
      if (dr[0]) break;
      t++;
    end
    if (t >= bound) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    din = w;
    din_valid = 1'b1;
    wait_accept(300);
  endtask

  task automatic wait_drain(input int bound);
    int t = 0;
    while (t < bound && !(wi[0] == wq.size() && wi[1] == wq.size() && !bv[0])) begin
      @(negedge clk);
      t++;
    end
    if (t >= bound) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_valid%0d", d), bv[d], 1'b0);
      chk($sformatf("rst_bits%0d", d), {bo[d], bl[d]}, 2'b00);
      chk($sformatf("rst_ready%0d", d), dr[d], 1'b1);
      chk($sformatf("rst_words%0d", d), ws[d], 16'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic count_run(input int exp_len);
    int n = 0;
    int t = 0;
    while (!bv[0] && t < 100) begin
      @(negedge clk);
      t++;
    end
    while (bv[0] && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_run_length", n, exp_len);
  endtask

  initial begin
    int t;
    do_reset();

    // Single word with accept-to-first-bit latency
    send_word(8'hA5);
    @(negedge clk);
    chk("latency_cycle1", bv[0], 1'b0);
    @(negedge clk);
    chk("latency_cycle2", bv[0], 1'b1);
    wait_drain(100);

    send_word(8'h01);
    wait_drain(100);

    // Back-to-back words with no gap
    fork
      begin
        send_word(8'hFF);
        send_word(8'h00);
        send_word(8'h5A);
      end
      count_run(3 * W);
    join
    wait_drain(100);

    // Stall in the middle of a word
    send_word(8'hC3);
    t = 0;
    while (bi[0] < 4 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    br_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    br_mode = 0;
    wait_drain(100);

    // Buffer full: one shifting, one held, a third must wait
    br_mode = 2;
    @(posedge clk);
    #1;
    send_word(8'h11);
    send_word(8'h22);
    din = 8'h33;
    din_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("full_not_ready", dr[0], 1'b0);
    end
    @(posedge clk);
    #1;
    br_mode = 0;
    wait_accept(300);
    wait_drain(200);

    // Reset mid-word with the buffer occupied
    send_word(8'h3C);
    send_word(8'h96);
    t = 0;
    while (bi[0] < 5 && t < 100) begin
      @(negedge clk);
      t++;
    end
    do_reset();
    repeat (20) @(posedge clk);
    #1;

    // Random words, gaps and backpressure
    br_mode = 1;
    for (int k = 0; k < 40; k++) begin
      send_word(W'($urandom));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    br_mode = 0;
    wait_drain(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
